// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment encode/decode blocks.
//   CODE_W    - symbol code width
//   SYM_*     - named symbol codes (digits 0..9 and letters A..F use their values)
//   PAT_*     - active-low segment patterns {DP, g..a}, shared with the forward encoders
package seg7_pkg;

    localparam int CODE_W = 5;

    localparam logic [CODE_W-1:0] SYM_H     = 5'd16;
    localparam logic [CODE_W-1:0] SYM_L     = 5'd17;
    localparam logic [CODE_W-1:0] SYM_DOT   = 5'd18;
    localparam logic [CODE_W-1:0] SYM_EXCL  = 5'd19;
    localparam logic [CODE_W-1:0] SYM_SMILE = 5'd20;
    localparam logic [CODE_W-1:0] SYM_BLANK = 5'd30;
    localparam logic [CODE_W-1:0] SYM_BAD   = 5'd31;

    localparam logic [7:0] PAT_0     = 8'hC0;
    localparam logic [7:0] PAT_1     = 8'hF9;
    localparam logic [7:0] PAT_2     = 8'hA4;
    localparam logic [7:0] PAT_3     = 8'hB0;
    localparam logic [7:0] PAT_4     = 8'h99;
    localparam logic [7:0] PAT_5     = 8'h92;
    localparam logic [7:0] PAT_6     = 8'h82;
    localparam logic [7:0] PAT_7     = 8'hF8;
    localparam logic [7:0] PAT_8     = 8'h80;
    localparam logic [7:0] PAT_9     = 8'h90;
    localparam logic [7:0] PAT_A     = 8'h88;
    localparam logic [7:0] PAT_B     = 8'h83;
    localparam logic [7:0] PAT_C     = 8'hC6;
    localparam logic [7:0] PAT_D     = 8'hA1;
    localparam logic [7:0] PAT_E     = 8'h86;
    localparam logic [7:0] PAT_F     = 8'h8E;
    localparam logic [7:0] PAT_H     = 8'h89;
    localparam logic [7:0] PAT_L     = 8'hC7;
    localparam logic [7:0] PAT_DOT   = 8'h7F;
    localparam logic [7:0] PAT_EXCL  = 8'h7D;
    localparam logic [7:0] PAT_SMILE = 8'hD5;
    localparam logic [7:0] PAT_BLANK = 8'hFF;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: combinational exact-match lookup of an active-low
// segment pattern to a symbol code.
//   seg   - 8-bit pattern {DP, g..a}
//   code  - symbol code, SYM_BAD when nothing matches
//   match - 1 when the pattern is a table entry
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [7:0]        seg,
    output logic [CODE_W-1:0] code,
    output logic              match
);

    always_comb begin
        match = 1'b1;
        case (seg)
            PAT_0:     code = 5'd0;
            PAT_1:     code = 5'd1;
            PAT_2:     code = 5'd2;
            PAT_3:     code = 5'd3;
            PAT_4:     code = 5'd4;
            PAT_5:     code = 5'd5;
            PAT_6:     code = 5'd6;
            PAT_7:     code = 5'd7;
            PAT_8:     code = 5'd8;
            PAT_9:     code = 5'd9;
            PAT_A:     code = 5'd10;
            PAT_B:     code = 5'd11;
            PAT_C:     code = 5'd12;
            PAT_D:     code = 5'd13;
            PAT_E:     code = 5'd14;
            PAT_F:     code = 5'd15;
            PAT_H:     code = SYM_H;
            PAT_L:     code = SYM_L;
            PAT_DOT:   code = SYM_DOT;
            PAT_EXCL:  code = SYM_EXCL;
            PAT_SMILE: code = SYM_SMILE;
            PAT_BLANK: code = SYM_BLANK;
            default: begin
                code  = SYM_BAD;
                match = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: monitors a multiplexed active-low 7-segment bus, captures
// each digit once its pattern has been stable, decodes it and publishes
// complete frames.
//   clk, rst     - clock, synchronous active-high reset
//   seg, an      - segment lines and digit enables (both active low)
//   codes        - last complete frame, digit i at [CODE_W*i +: CODE_W]
//   frame_valid  - one-cycle pulse aligned with a codes update
//   bad_pattern  - sticky, a captured pattern was not in the table
//   an_conflict  - sticky, more than one anode was active in a cycle
//   clr_err      - clears the sticky flags (a same-cycle new error wins)
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CODE_W        = seg7_pkg::CODE_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   seg,
    input  logic [NUM_DIGITS-1:0]        an,
    output logic [CODE_W*NUM_DIGITS-1:0] codes,
    output logic                         frame_valid,
    output logic                         bad_pattern,
    output logic                         an_conflict,
    input  logic                         clr_err
);
    import seg7_pkg::*;

    localparam int KW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [7:0]            seg_s1, prev_seg;
    logic [NUM_DIGITS-1:0] an_s1;
    logic [KW-1:0]         k, prev_k;
    logic [3:0]            nz;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic                  same, cap_nxt, cap_r;

    logic [NUM_DIGITS-1:0]              seen, seen_nxt;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]  wbuf, wbuf_nxt, codes_r;

    logic [CODE_W-1:0] dcode;
    logic              dmatch;

    assign codes = codes_r;

    // Count active (low) anodes and find the index of the active one.
    always_comb begin
        nz = 4'd0;
        k  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s1[i]) begin
                nz = nz + 4'd1;
                k  = KW'(i);
            end
        end
    end

    // cnt==0 means no dwell in progress, so prev_* is only trusted when cnt!=0.
    assign same = (cnt != '0) && (k == prev_k) && (seg_s1 == prev_seg);

    always_comb begin
        if (nz != 4'd1)
            cnt_nxt = '0;
        else if (same)
            cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        else
            cnt_nxt = CW'(1);
    end

    // Fire once when the dwell first reaches the threshold; a dwell already
    // sitting at saturation does not fire again.
    assign cap_nxt = (nz == 4'd1) && (cnt_nxt == CNT_MAX) && !(same && (cnt == CNT_MAX));

    // The captured sample lives in prev_* during the cycle cap_r is high.
    seg7_pattern_decode u_dec (
        .seg   (prev_seg),
        .code  (dcode),
        .match (dmatch)
    );

    always_comb begin
        wbuf_nxt = wbuf;
        seen_nxt = seen;
        if (cap_r) begin
            wbuf_nxt[prev_k] = dcode;
            seen_nxt[prev_k] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1      <= '0;
            an_s1       <= '1;
            prev_seg    <= '0;
            prev_k      <= '0;
            cnt         <= '0;
            cap_r       <= 1'b0;
            seen        <= '0;
            wbuf        <= {NUM_DIGITS{SYM_BLANK}};
            codes_r     <= {NUM_DIGITS{SYM_BLANK}};
            frame_valid <= 1'b0;
            bad_pattern <= 1'b0;
            an_conflict <= 1'b0;
        end else begin
            seg_s1   <= seg;
            an_s1    <= an;
            prev_seg <= seg_s1;
            prev_k   <= k;
            cnt      <= cnt_nxt;
            cap_r    <= cap_nxt;
            wbuf     <= wbuf_nxt;

            frame_valid <= 1'b0;
            if (&seen_nxt) begin
                codes_r     <= wbuf_nxt;
                seen        <= '0;
                frame_valid <= 1'b1;
            end else begin
                seen <= seen_nxt;
            end

            if (cap_r && !dmatch)
                bad_pattern <= 1'b1;
            else if (clr_err)
                bad_pattern <= 1'b0;

            if (nz > 4'd1)
                an_conflict <= 1'b1;
            else if (clr_err)
                an_conflict <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: expected frames are queued by the
// stimulus; a monitor pops and compares on every frame_valid.
module tb_seg7_scan_decoder;

    logic        clk = 1'b0;
    logic        rst, clr_err;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [19:0] codes;
    logic        frame_valid, bad_pattern, an_conflict;

    seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .codes       (codes),
        .frame_valid (frame_valid),
        .bad_pattern (bad_pattern),
        .an_conflict (an_conflict),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    logic [19:0] exp_q[$];
    int checks = 0;
    int passes = 0;
    int frames = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [19:0] pk(input logic [4:0] d3, input logic [4:0] d2,
                                       input logic [4:0] d1, input logic [4:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (frame_valid) begin
            frames++;
            if (exp_q.size() == 0) chk("unexpected_frame", {31'd0, frame_valid}, 32'd0);
            else chk("frame_codes", {12'd0, codes}, {12'd0, exp_q.pop_front()});
        end
    end

    task automatic dwell(input int k, input logic [7:0] p, input int n);
        an    = 4'hF;
        an[k] = 1'b0;
        seg   = p;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        an  = 4'hF;
        seg = 8'hFF;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [7:0] p0, input logic [7:0] p1,
                        input logic [7:0] p2, input logic [7:0] p3);
        dwell(0, p0, 8);
        dwell(1, p1, 8);
        dwell(2, p2, 8);
        dwell(3, p3, 8);
        idle(4);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int f0;
        rst = 1'b1; clr_err = 1'b0; an = 4'hF; seg = 8'hFF;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk("rst_codes", {12'd0, codes}, {12'd0, pk(30, 30, 30, 30)});
        chk("rst_fv", {31'd0, frame_valid}, 32'd0);
        chk("rst_bad", {31'd0, bad_pattern}, 32'd0);
        chk("rst_conf", {31'd0, an_conflict}, 32'd0);

        // basic scan with latency measurement on the last digit
        exp_q.push_back(pk(3, 2, 1, 0));
        dwell(0, 8'hC0, 8);
        dwell(1, 8'hF9, 8);
        dwell(2, 8'hA4, 8);
        an = 4'h7; seg = 8'hB0;
        n = 0;
        while (!frame_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 6);
        repeat (2) @(negedge clk);
        idle(4);
        chk("scan1_bad", {31'd0, bad_pattern}, 32'd0);
        chk("scan1_conf", {31'd0, an_conflict}, 32'd0);

        // short dwell is ignored
        exp_q.push_back(pk(13, 12, 11, 10));
        dwell(2, 8'h99, 3);
        scan(8'h88, 8'h83, 8'hC6, 8'hA1);

        // unknown pattern
        exp_q.push_back(pk(17, 15, 31, 14));
        scan(8'h86, 8'h55, 8'h8E, 8'hC7);
        chk("bad_set", {31'd0, bad_pattern}, 32'd1);
        chk("bad_noconf", {31'd0, an_conflict}, 32'd0);
        pulse_clr();
        chk("bad_clr", {31'd0, bad_pattern}, 32'd0);

        // anode conflict mid-scan
        exp_q.push_back(pk(1, 0, 9, 8));
        dwell(0, 8'h80, 8);
        dwell(1, 8'h90, 8);
        an = 4'b1100; seg = 8'h80;
        @(negedge clk);
        dwell(2, 8'hC0, 8);
        dwell(3, 8'hF9, 8);
        idle(4);
        chk("conf_set", {31'd0, an_conflict}, 32'd1);
        chk("conf_nobad", {31'd0, bad_pattern}, 32'd0);
        pulse_clr();
        chk("conf_clr", {31'd0, an_conflict}, 32'd0);

        // reset mid-frame
        f0 = frames;
        dwell(0, 8'h80, 8);
        dwell(1, 8'h90, 8);
        idle(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_codes", {12'd0, codes}, {12'd0, pk(30, 30, 30, 30)});
        idle(6);
        chk("midrst_noframe", frames, f0);
        exp_q.push_back(pk(20, 19, 17, 16));
        scan(8'h89, 8'hC7, 8'h7D, 8'hD5);

        // ghosting: toggling digit 0 never captured
        dwell(1, 8'hF9, 8);
        dwell(2, 8'hA4, 8);
        dwell(3, 8'hB0, 8);
        f0 = frames;
        for (int i = 0; i < 6; i++) begin
            dwell(0, 8'h80, 2);
            dwell(0, 8'h90, 2);
        end
        idle(6);
        chk("toggle_noframe", frames, f0);
        exp_q.push_back(pk(3, 2, 1, 18));
        dwell(0, 8'h7F, 8);
        idle(4);

        chk("queue_empty", exp_q.size(), 0);
        chk("bad_final", {31'd0, bad_pattern}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
